ddr_20g_adc_gen: RTL and testbench
==================================

DDR_20G_ADC_GEN -- requirements
Module: ddr_20g_adc_gen

Interface
REQ-001 SHALL have parameter DATA_WD, default 256, pattern bus width; only 256 is supported.
REQ-002 SHALL have parameter GAP_WD, default 8, width of cfg_gap.
REQ-003 SHALL have port clk  input  1  sole clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_rst  input  1  synchronous clear of generator state and counters.
REQ-006 SHALL have port cfg_start  input  1  single-cycle pulse that starts a run.
REQ-007 SHALL have port cfg_stop  input  1  single-cycle pulse that ends a run at the next beat boundary.
REQ-008 SHALL have port cfg_beat_num  input  32  beats per run; 0 = continuous.
REQ-009 SHALL have port cfg_gap  input  GAP_WD  idle cycles inserted after each accepted beat.
REQ-010 SHALL have port adc_rdy  input  1  downstream ready.
REQ-011 SHALL have port adc_vld  output  1  beat valid.
REQ-012 SHALL have port adc_data  output  DATA_WD  pattern beat.
REQ-013 SHALL have port gen_busy  output  1  high while a run is active.
REQ-014 SHALL have port gen_done  output  1  one-cycle pulse when a run ends.
REQ-015 SHALL have port beat_cnt  output  32  accepted beats in the current or last run.

Function
REQ-016 SHALL transfer a beat only on cycles where adc_vld and adc_rdy are both 1.
REQ-017 SHALL hold adc_vld and adc_data stable while adc_vld=1 and adc_rdy=0.
REQ-018 SHALL use FSM states IDLE, SEND, GAP, DONE.
REQ-019 IDLE: adc_vld=0; on cfg_start go to SEND next cycle, with beat_cnt cleared and pattern base cleared to 0.
REQ-020 SEND: adc_vld=1; on transfer go to DONE if the beat was the last (beat_cnt+1==cfg_beat_num with cfg_beat_num!=0, or stop pending), else GAP if cfg_gap!=0, else stay in SEND.
REQ-021 GAP: adc_vld=0 for exactly cfg_gap cycles (sampled at the transfer), then SEND; a pending stop goes to DONE instead.
REQ-022 DONE: gen_done=1 for one cycle, then IDLE.
REQ-023 cfg_stop SHALL be latched as stop pending; it never drops a beat already presented with adc_vld=1.
REQ-024 cfg_start outside IDLE SHALL be ignored.
REQ-025 Pattern: 16-bit lanes; base b; adc_data = 4 repeats of {b+3,b+2,b+1,b} (lane 0 in bits 15:0 = b); each lane wraps mod 2^16.
REQ-026 b SHALL advance by 4 (mod 2^16) after every second transferred beat; beats 0,1 use b=0, beats 2,3 use b=4.
REQ-027 beat_cnt SHALL increment by 1 per transfer, wrap at 2^32, and hold after the run until the next cfg_start or cfg_rst.
REQ-028 First adc_vld SHALL rise exactly 1 cycle after cfg_start is sampled.
REQ-029 gen_busy SHALL be 1 in SEND and GAP, 0 in IDLE and DONE.
REQ-030 cfg_rst mid-run SHALL force IDLE next cycle, clear b, beat_cnt and stop pending, and suppress gen_done.
REQ-031 cfg_rst SHALL take priority over cfg_start and cfg_stop in the same cycle.

Reset
REQ-032 On rst_n=0: state IDLE, adc_vld=0, adc_data=0, gen_busy=0, gen_done=0, beat_cnt=0, b=0, stop pending=0, gap counter=0.
REQ-033 Reset assertion SHALL take effect without a clock edge; deassertion SHALL be synchronous to clk.

Configuration
REQ-034 Macro ADC_GEN_ERR_INJ_EN SHALL, when defined, add input cfg_err_inj (1 bit, pulse).
REQ-035 With ADC_GEN_ERR_INJ_EN defined, cfg_err_inj SHALL invert bit 0 of the next transferred beat only; b and beat_cnt are unaffected; a second pulse before that transfer is merged.
REQ-036 Without ADC_GEN_ERR_INJ_EN, the port and all injection logic SHALL be absent; output is always the clean pattern.

Verification
REQ-037 cfg_beat_num=4, cfg_gap=0, adc_rdy=1, start -> 4 consecutive beats with lane0 values 0,0,4,4; gen_done 1 cycle after 4th beat; beat_cnt=4.
REQ-038 cfg_gap=3, cfg_beat_num=3 -> exactly 3 idle cycles between beats; gen_done after beat 3.
REQ-039 adc_rdy low for 5 cycles on beat 2 -> adc_vld and adc_data held stable; no beat lost or duplicated; beat_cnt=3 at end.
REQ-040 cfg_beat_num=0, run 32770 beats -> lane0 wraps 0xFFFC to 0x0000 between beats 32767 and 32768; cfg_stop -> DONE after the in-flight beat.
REQ-041 cfg_rst during GAP -> IDLE next cycle, beat_cnt=0, no gen_done; rst_n pulse mid-SEND -> adc_vld=0 immediately.
REQ-042 With ADC_GEN_ERR_INJ_EN, cfg_err_inj before beat 1 of a 4-beat run -> downstream checker counts 3 successes, 1 error.

Source files
------------

// File: rtl/ddr_20g_adc_gen_if.sv
// ddr_20g_adc_gen_if -- beat stream between the ADC pattern generator and its sink.
//   adc_vld  : beat valid (generator -> sink)
//   adc_rdy  : sink ready (sink -> generator)
//   adc_data : pattern beat, DATA_WD bits (generator -> sink)
// A beat moves on every clock where adc_vld and adc_rdy are both high.
interface ddr_20g_adc_gen_if #(
   parameter int DATA_WD = 256
);
   logic               adc_vld;
   logic               adc_rdy;
   logic [DATA_WD-1:0] adc_data;

   modport master (
      output adc_vld,
      output adc_data,
      input  adc_rdy
   );

   modport slave (
      input  adc_vld,
      input  adc_data,
      output adc_rdy
   );
endinterface

// File: rtl/ddr_20g_adc_gen.sv
// ddr_20g_adc_gen -- ADC test-pattern beat generator.
//
// Emits runs of 256-bit beats made of sixteen 16-bit lanes. Lane i carries
// b + (i mod 4), where the base b starts at 0 for each run and advances by 4
// after every second accepted beat. A run is started by cfg_start, lasts
// cfg_beat_num beats (0 = until cfg_stop), and can insert cfg_gap idle cycles
// after each accepted beat.
//
// Ports
//   clk           : sole clock, rising edge
//   rst_n         : asynchronous active-low reset
//   cfg_rst       : synchronous clear of generator state and counters
//   cfg_start     : start pulse (ignored unless idle)
//   cfg_stop      : stop pulse, run ends after the beat in flight
//   cfg_beat_num  : beats per run, 0 = continuous
//   cfg_gap       : idle cycles after each accepted beat
//   cfg_err_inj   : (ADC_GEN_ERR_INJ_EN only) flip bit 0 of the next accepted beat
//   adc           : beat stream, master side (adc_vld/adc_data out, adc_rdy in)
//   gen_busy      : run active (SEND or GAP)
//   gen_done      : one-cycle pulse as a run ends
//   beat_cnt      : accepted beats in the current or last run
//
// Build option: define ADC_GEN_ERR_INJ_EN to add the cfg_err_inj port and the
// single-bit error injection path. Without it the output is always clean.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no run; adc_vld low, waiting for cfg_start
// SEND  | beat presented with adc_vld high until accepted
// GAP   | idle cycles after an accepted beat, counted down in gap_cnt_q
// DONE  | gen_done pulse for one cycle, then back to IDLE
module ddr_20g_adc_gen #(
   parameter int DATA_WD = 256,
   parameter int GAP_WD  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_rst,
   input  logic              cfg_start,
   input  logic              cfg_stop,
   input  logic [31:0]       cfg_beat_num,
   input  logic [GAP_WD-1:0] cfg_gap,
`ifdef ADC_GEN_ERR_INJ_EN
   input  logic              cfg_err_inj,
`endif
   ddr_20g_adc_gen_if.master adc,
   output logic              gen_busy,
   output logic              gen_done,
   output logic [31:0]       beat_cnt
);

   localparam int LANES = DATA_WD / 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       beat_cnt_q, beat_cnt_d;
   logic [GAP_WD-1:0] gap_cnt_q, gap_cnt_d;
   logic              stop_q, stop_d;

   logic              vld;
   logic              xfer;
   logic              stop_any;
   logic              last_beat;
   logic [15:0]       base;
   logic [DATA_WD-1:0] pattern;
   logic              err_bit;

   assign vld      = (state_q == ST_SEND);
   assign xfer     = vld & adc.adc_rdy;
   // A stop pulse arriving in the same cycle as a transfer still makes that
   // transfer the last one of the run.
   assign stop_any = stop_q | cfg_stop;
   assign last_beat = ((beat_cnt_q + 32'd1 == cfg_beat_num) && (cfg_beat_num != 32'd0))
                      || stop_any;

   // The base advances every second beat of the run, so it follows directly
   // from the accepted-beat count: b = 4 * floor(n/2) mod 2^16.
   assign base = {beat_cnt_q[14:1], 2'b00};

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign pattern[i*16 +: 16] = base + 16'(i % 4);
   end

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      stop_d     = stop_q;

      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               state_d    = ST_SEND;
               beat_cnt_d = 32'd0;
               gap_cnt_d  = '0;
               stop_d     = 1'b0;
            end
         end
         ST_SEND: begin
            if (cfg_stop) stop_d = 1'b1;
            if (xfer) begin
               beat_cnt_d = beat_cnt_q + 32'd1;
               if (last_beat) begin
                  state_d = ST_DONE;
                  stop_d  = 1'b0;
               end else if (cfg_gap != '0) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = cfg_gap;
               end
            end
         end
         ST_GAP: begin
            if (cfg_stop) stop_d = 1'b1;
            if (gap_cnt_q <= GAP_WD'(1)) begin
               gap_cnt_d = '0;
               if (stop_any) begin
                  state_d = ST_DONE;
                  stop_d  = 1'b0;
               end else begin
                  state_d = ST_SEND;
               end
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_WD'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (cfg_rst) begin
         state_d    = ST_IDLE;
         beat_cnt_d = 32'd0;
         gap_cnt_d  = '0;
         stop_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         beat_cnt_q <= 32'd0;
         gap_cnt_q  <= '0;
         stop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         stop_q     <= stop_d;
      end
   end

`ifdef ADC_GEN_ERR_INJ_EN
   // err_q marks the beat currently presented (or the next one to be
   // presented) as corrupted. Requests arriving while a beat is stalled are
   // parked in req_q so the held beat never changes; repeated requests merge.
   logic err_q, err_d;
   logic req_q, req_d;
   logic stall;

   assign stall = vld & ~adc.adc_rdy;

   always_comb begin
      err_d = err_q;
      req_d = req_q | cfg_err_inj;
      if (!stall) begin
         err_d = (xfer ? 1'b0 : err_q) | req_d;
         req_d = 1'b0;
      end
      if (cfg_rst) begin
         err_d = 1'b0;
         req_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
         req_q <= 1'b0;
      end else begin
         err_q <= err_d;
         req_q <= req_d;
      end
   end

   assign err_bit = err_q;
`else
   assign err_bit = 1'b0;
`endif

   assign adc.adc_vld  = vld;
   assign adc.adc_data = vld ? (pattern ^ {{(DATA_WD-1){1'b0}}, err_bit}) : '0;

   assign gen_busy = (state_q == ST_SEND) || (state_q == ST_GAP);
   assign gen_done = (state_q == ST_DONE);
   assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_ddr_20g_adc_gen.sv
module tb_ddr_20g_adc_gen;
   localparam int DW = 256;
   localparam int GW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_rst = 1'b0;
   logic          cfg_start = 1'b0;
   logic          cfg_stop = 1'b0;
   logic [31:0]   cfg_beat_num = 32'd0;
   logic [GW-1:0] cfg_gap = '0;
`ifdef ADC_GEN_ERR_INJ_EN
   logic          cfg_err_inj = 1'b0;
`endif
   logic          gen_busy;
   logic          gen_done;
   logic [31:0]   beat_cnt;

   ddr_20g_adc_gen_if #(.DATA_WD(DW)) adc_bus ();

   ddr_20g_adc_gen #(.DATA_WD(DW), .GAP_WD(GW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_rst      (cfg_rst),
      .cfg_start    (cfg_start),
      .cfg_stop     (cfg_stop),
      .cfg_beat_num (cfg_beat_num),
      .cfg_gap      (cfg_gap),
`ifdef ADC_GEN_ERR_INJ_EN
      .cfg_err_inj  (cfg_err_inj),
`endif
      .adc          (adc_bus),
      .gen_busy     (gen_busy),
      .gen_done     (gen_done),
      .beat_cnt     (beat_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference pattern: beat n of a run uses base 4*floor(n/2), lane i = base + i%4.
   function automatic logic [DW-1:0] exp_data(input int n);
      logic [DW-1:0] r;
      int b;
      b = ((n / 2) * 4) % 65536;
      for (int i = 0; i < DW / 16; i++) r[i*16 +: 16] = 16'((b + (i % 4)) % 65536);
      return r;
   endfunction

   // ready driver
   int rdy_pct = 100;
   initial begin
      adc_bus.adc_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         adc_bus.adc_rdy = ($urandom_range(99) < rdy_pct);
      end
   end

   // stream monitor / scoreboard
   bit            mon_en = 1'b0;
   bit            chk_spur = 1'b1;
   int            mon_cnt = 0;
   int            cur_num = 0;
   int            cur_gap = 0;
   int            err_idx = -1;
   int            idle = 0;
   bit            stop_seen = 1'b0;
   bit            prev_vld = 1'b0;
   bit            prev_stall = 1'b0;
   bit            prev_done = 1'b0;
   bit            done_exp = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic [15:0]   lane0_a = '0;
   logic [15:0]   lane0_b = '0;

   always @(negedge clk) begin
      if (mon_en) begin
         logic [DW-1:0] e;
         if (cfg_stop) stop_seen = 1'b1;
         if (done_exp) begin
            chk("done_after_last", gen_done, 1);
            chk("busy_in_done", gen_busy, 0);
            done_exp = 1'b0;
         end else if (chk_spur && gen_done) begin
            chk("spurious_done", gen_done, 0);
         end
         if (prev_done) chk("done_width", gen_done, 0);
         prev_done = gen_done;
         if (prev_stall) begin
            chk("stall_vld", adc_bus.adc_vld, 1);
            chk("stall_data", adc_bus.adc_data, prev_data);
         end
         if (adc_bus.adc_vld) begin
            if (!prev_vld && mon_cnt > 0) chk("gap_len", idle, cur_gap);
            e = exp_data(mon_cnt);
            if (mon_cnt == err_idx) e[0] = ~e[0];
            chk("beat_data", adc_bus.adc_data, e);
            idle = 0;
         end else if (gen_busy) begin
            idle++;
         end else begin
            idle = 0;
         end
         if (adc_bus.adc_vld && adc_bus.adc_rdy) begin
            if (mon_cnt == 32767) lane0_a = adc_bus.adc_data[15:0];
            if (mon_cnt == 32768) lane0_b = adc_bus.adc_data[15:0];
            mon_cnt++;
            if ((cur_num != 0 && mon_cnt == cur_num) || stop_seen) done_exp = 1'b1;
         end
         prev_stall = adc_bus.adc_vld && !adc_bus.adc_rdy;
         prev_vld   = adc_bus.adc_vld;
         prev_data  = adc_bus.adc_data;
      end
   end

   task automatic start_run(input int num, input int gap, input int pct);
      @(posedge clk);
      #1;
      cfg_beat_num = 32'(num);
      cfg_gap      = GW'(gap);
      rdy_pct      = pct;
      cur_num      = num;
      cur_gap      = gap;
      mon_cnt      = 0;
      stop_seen    = 1'b0;
      prev_vld     = 1'b0;
      prev_stall   = 1'b0;
      done_exp     = 1'b0;
      idle         = 0;
      cfg_start    = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      @(negedge clk);
      chk("first_vld", adc_bus.adc_vld, 1);
   endtask

   task automatic wait_done(input int lim);
      int k = 0;
      while (gen_done !== 1'b1 && k < lim) begin
         @(negedge clk);
         k++;
      end
      if (gen_done !== 1'b1) chk("done_timeout", gen_done, 1);
   endtask

   task automatic wait_beats(input int n, input int lim);
      int k = 0;
      while (mon_cnt < n && k < lim) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (mon_cnt < n) chk("beat_timeout", mon_cnt, n);
   endtask

   typedef struct {
      int num;
      int gap;
      int pct;
      int exp_beats;
   } vec_t;

   vec_t tbl [8];

   initial begin
      tbl[0] = '{4, 0, 100, 4};
      tbl[1] = '{3, 3, 100, 3};
      tbl[2] = '{5, 1, 50, 5};
      tbl[3] = '{8, 0, 60, 8};
      tbl[4] = '{6, 2, 30, 6};
      tbl[5] = '{1, 0, 100, 1};
      tbl[6] = '{2, 5, 70, 2};
      tbl[7] = '{7, 255, 80, 7};

      // reset state, checked while rst_n is still asserted
      #12;
      chk("rst_vld", adc_bus.adc_vld, 0);
      chk("rst_data", adc_bus.adc_data, '0);
      chk("rst_busy", gen_busy, 0);
      chk("rst_done", gen_done, 0);
      chk("rst_beat_cnt", beat_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1'b1;

      for (int v = 0; v < 8; v++) begin
         start_run(tbl[v].num, tbl[v].gap, tbl[v].pct);
         wait_done(5000);
         chk("tbl_beat_cnt", beat_cnt, 32'(tbl[v].exp_beats));
         chk("tbl_beats_seen", mon_cnt, tbl[v].exp_beats);
         @(negedge clk);
         chk("tbl_idle_busy", gen_busy, 0);
         chk("tbl_hold_cnt", beat_cnt, 32'(tbl[v].exp_beats));
      end

      // beat 2 held off for several cycles: held stable, nothing lost
      start_run(3, 0, 100);
      wait_beats(2, 100);
      rdy_pct = 0;
      repeat (5) @(posedge clk);
      #2;
      rdy_pct = 100;
      wait_done(200);
      chk("stall_beat_cnt", beat_cnt, 3);
      chk("stall_beats_seen", mon_cnt, 3);

      // cfg_start during a run is ignored
      start_run(4, 2, 100);
      wait_beats(2, 100);
      @(posedge clk);
      #1;
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      wait_done(200);
      chk("restart_beat_cnt", beat_cnt, 4);
      chk("restart_beats_seen", mon_cnt, 4);

      // cfg_rst beats cfg_start in the same cycle
      @(posedge clk);
      #1;
      cfg_rst = 1'b1;
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      cfg_rst = 1'b0;
      cfg_start = 1'b0;
      @(negedge clk);
      chk("rst_prio_busy", gen_busy, 0);
      chk("rst_prio_vld", adc_bus.adc_vld, 0);
      chk("rst_prio_cnt", beat_cnt, 0);

      // cfg_rst during GAP: idle next cycle, counter cleared, no done pulse
      start_run(5, 4, 100);
      wait_beats(1, 100);
      @(posedge clk);
      #1;
      cfg_rst = 1'b1;
      @(posedge clk);
      #1;
      cfg_rst = 1'b0;
      @(negedge clk);
      chk("gaprst_busy", gen_busy, 0);
      chk("gaprst_vld", adc_bus.adc_vld, 0);
      chk("gaprst_cnt", beat_cnt, 0);
      repeat (10) @(negedge clk);

      // cfg_stop during GAP ends the run once the gap expires
      chk_spur = 1'b0;
      start_run(0, 3, 100);
      wait_beats(1, 100);
      @(posedge clk);
      #1;
      cfg_stop = 1'b1;
      @(posedge clk);
      #1;
      cfg_stop = 1'b0;
      wait_done(50);
      chk("gapstop_beat_cnt", beat_cnt, 1);
      chk("gapstop_beats_seen", mon_cnt, 1);
      @(negedge clk);
      chk_spur = 1'b1;

      // rst_n pulse while a beat is stalled in SEND: vld drops without a clock
      mon_en = 1'b0;
      start_run(0, 0, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_vld", adc_bus.adc_vld, 0);
      chk("arst_busy", gen_busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1'b1;

`ifdef ADC_GEN_ERR_INJ_EN
      // error injection before the first beat corrupts exactly that beat
      @(posedge clk);
      #1;
      cfg_err_inj = 1'b1;
      @(posedge clk);
      #1;
      cfg_err_inj = 1'b0;
      err_idx = 0;
      start_run(4, 0, 100);
      wait_done(100);
      chk("errinj_beat_cnt", beat_cnt, 4);
      err_idx = -1;
`endif

      // continuous run across the 16-bit base wrap, ended by cfg_stop
      start_run(0, 0, 100);
      wait_beats(32769, 40000);
      @(posedge clk);
      #1;
      cfg_stop = 1'b1;
      @(posedge clk);
      #1;
      cfg_stop = 1'b0;
      wait_done(50);
      chk("wrap_beat_cnt", beat_cnt, 32770);
      chk("wrap_beats_seen", mon_cnt, 32770);
      chk("wrap_lane0_32767", lane0_a, 16'hFFFC);
      chk("wrap_lane0_32768", lane0_b, 16'h0000);
      repeat (3) @(negedge clk);
      chk("wrap_idle_vld", adc_bus.adc_vld, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
